// File: rtl/washer_pkg.sv
// Shared definitions for the washing-machine water inlet scheduler.
//   DefNMach       : default number of machines sharing the inlet valve
//   DefTickDiv     : default clk cycles per time tick
//   DefFillTimeout : default maximum fill duration in ticks
//   fill_state_e   : scheduler FSM state encoding
package washer_pkg;

    localparam int unsigned DefNMach       = 4;
    localparam int unsigned DefTickDiv     = 20000000;
    localparam int unsigned DefFillTimeout = 30;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StClose
    } fill_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick prescaler with synchronous clear.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   clr_i   : synchronous clear, counter returns to 0 on the next edge
//   tick_o  : high for one cycle while the counter sits at TICK_DIV-1
module tick_prescaler
    import washer_pkg::*;
#(
    parameter int unsigned TICK_DIV = DefTickDiv
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned    CntW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/water_fill_scheduler.sv
// Round-robin scheduler sharing one water inlet valve among N_MACH machines.
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   power      : global enable, low forces IDLE
//   fill_req   : per-machine request for water
//   water_full : per-machine level sensor
//   fault_clr  : per-machine fault clear (set wins on collision)
//   valve_open : main inlet valve drive
//   valve_sel  : one-hot routing to the granted machine
//   fill_done  : one-cycle pulse when the granted machine reports full
//   fault      : sticky per-machine fill-timeout flag
//   busy       : high whenever the FSM is not IDLE
module water_fill_scheduler
    import washer_pkg::*;
#(
    parameter int unsigned N_MACH       = DefNMach,
    parameter int unsigned TICK_DIV     = DefTickDiv,
    parameter int unsigned FILL_TIMEOUT = DefFillTimeout
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              power,
    input  logic [N_MACH-1:0] fill_req,
    input  logic [N_MACH-1:0] water_full,
    input  logic [N_MACH-1:0] fault_clr,
    output logic              valve_open,
    output logic [N_MACH-1:0] valve_sel,
    output logic [N_MACH-1:0] fill_done,
    output logic [N_MACH-1:0] fault,
    output logic              busy
);

    localparam int unsigned      IdxW    = (N_MACH > 1) ? $clog2(N_MACH) : 1;
    localparam int unsigned      TckW    = (FILL_TIMEOUT > 0) ? $clog2(FILL_TIMEOUT + 1) : 1;
    localparam logic [TckW-1:0]  TckLast = TckW'(FILL_TIMEOUT - 1);
    localparam logic [N_MACH-1:0] OneHot0 = N_MACH'(1);

    fill_state_e       state_q, state_d;
    logic [IdxW-1:0]   grant_q, grant_d;
    logic [IdxW-1:0]   rr_q, rr_d;
    logic [N_MACH-1:0] fault_q, fault_d, fault_set;
    logic [TckW-1:0]   tcnt_q, tcnt_d;
    logic              tick;
    logic              timeout;

    // Prescaler is held cleared outside FILL so every fill starts from a fresh tick phase.
    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (state_q != StFill),
        .tick_o  (tick)
    );

    // Timeout fires on the tick that would bring the counter to FILL_TIMEOUT,
    // so the valve is open for exactly FILL_TIMEOUT * TICK_DIV cycles.
    assign timeout = tick && (tcnt_q == TckLast);

    always_comb begin
        tcnt_d = '0;
        if (state_q == StFill) begin
            tcnt_d = tick ? tcnt_q + 1'b1 : tcnt_q;
        end
    end

    // Round-robin search of eligible requesters starting at rr_q.
    logic [N_MACH-1:0] elig;
    logic              found;
    logic [IdxW-1:0]   pick;
    logic [IdxW-1:0]   idx;

    assign elig = fill_req & ~fault_q;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned i = 0; i < N_MACH; i++) begin
            idx = IdxW'((32'(rr_q) + i) % N_MACH);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        fault_set = '0;
        fill_done = '0;
        if (!power) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        state_d = StFill;
                        grant_d = pick;
                    end
                end
                StFill: begin
                    if (water_full[grant_q]) begin
                        fill_done[grant_q] = 1'b1;
                        state_d            = StClose;
                    end else if (!fill_req[grant_q]) begin
                        state_d = StClose;
                    end else if (timeout) begin
                        fault_set[grant_q] = 1'b1;
                        state_d            = StClose;
                    end
                end
                StClose: begin
                    rr_d    = (grant_q == IdxW'(N_MACH - 1)) ? '0 : grant_q + 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
        fault_d = (fault_q & ~fault_clr) | fault_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            rr_q    <= '0;
            fault_q <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            fault_q <= fault_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Valve drive decodes straight from the state register so reset closes it at once.
    assign valve_open = (state_q == StFill);
    assign valve_sel  = valve_open ? (OneHot0 << grant_q) : '0;
    assign fault      = fault_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_water_fill_scheduler.sv
// Bench for water_fill_scheduler: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a cycle-count model.
module tb_water_fill_scheduler;

    localparam int N        = 4;
    localparam int TD       = 4;
    localparam int FT       = 3;
    localparam int FILL_CYC = TD * FT;

    logic       clk        = 1'b0;
    logic       reset_n    = 1'b0;
    logic       power      = 1'b0;
    logic [3:0] fill_req   = '0;
    logic [3:0] water_full = '0;
    logic [3:0] fault_clr  = '0;
    logic       valve_open;
    logic [3:0] valve_sel;
    logic [3:0] fill_done;
    logic [3:0] fault;
    logic       busy;

    int checks = 0;
    int errors = 0;

    water_fill_scheduler #(
        .N_MACH       (N),
        .TICK_DIV     (TD),
        .FILL_TIMEOUT (FT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .power      (power),
        .fill_req   (fill_req),
        .water_full (water_full),
        .fault_clr  (fault_clr),
        .valve_open (valve_open),
        .valve_sel  (valve_sel),
        .fill_done  (fill_done),
        .fault      (fault),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 = no grant, 1 = valve open for machine m_g, 2 = closing.
    // The fill duration is tracked as a plain cycle count rather than ticks.
    int         m_phase = 0;
    int         m_cyc   = 0;
    logic [1:0] m_g     = '0;
    logic [1:0] m_rr    = '0;
    logic [3:0] m_fault = '0;

    always @(negedge clk) begin
        logic       e_open, e_busy;
        logic [3:0] e_sel, e_done, nf;
        logic [1:0] j;
        int         pick;
        if (!reset_n) begin
            m_phase = 0;
            m_cyc   = 0;
            m_g     = '0;
            m_rr    = '0;
            m_fault = '0;
        end
        e_open = (m_phase == 1);
        e_sel  = e_open ? 4'(1 << m_g) : 4'b0;
        e_done = (e_open && power && water_full[m_g]) ? e_sel : 4'b0;
        e_busy = (m_phase != 0);
        check("model_outputs", 32'({valve_open, valve_sel, fill_done, fault, busy}),
              32'({e_open, e_sel, e_done, m_fault, e_busy}));
        if (reset_n) begin
            nf = m_fault & ~fault_clr;
            if (!power) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                pick = -1;
                for (int k = 0; k < N; k++) begin
                    j = 2'((int'(m_rr) + k) % N);
                    if (pick < 0 && fill_req[j] && !m_fault[j]) pick = int'(j);
                end
                if (pick >= 0) begin
                    m_phase = 1;
                    m_g     = 2'(pick);
                    m_cyc   = 0;
                end
            end else if (m_phase == 1) begin
                if (water_full[m_g]) begin
                    m_phase = 2;
                end else if (!fill_req[m_g]) begin
                    m_phase = 2;
                end else if (m_cyc == FILL_CYC - 1) begin
                    nf[m_g] = 1'b1;
                    m_phase = 2;
                end else begin
                    m_cyc++;
                end
            end else begin
                m_rr    = 2'((int'(m_g) + 1) % N);
                m_phase = 0;
            end
            m_fault = nf;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        power      = 1'b0;
        fill_req   = '0;
        water_full = '0;
        fault_clr  = '0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset values
        do_reset();
        #1;
        check("rst_valve_open", 32'(valve_open), 0);
        check("rst_valve_sel", 32'(valve_sel), 0);
        check("rst_fill_done", 32'(fill_done), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_busy", 32'(busy), 0);

        // Two requesters, full after 10 fill cycles, round-robin moves on to machine 2
        power    = 1'b1;
        fill_req = 4'b0101;
        step(); #1;
        check("a_grant0_sel", 32'(valve_sel), 1);
        check("a_grant0_open", 32'(valve_open), 1);
        repeat (9) step();
        water_full = 4'b0001;
        #1;
        check("a_fill_done0", 32'(fill_done), 1);
        step();
        water_full = '0;
        #1;
        check("a_close_valve", 32'(valve_open), 0);
        check("a_close_busy", 32'(busy), 1);
        step(); #1;
        check("a_idle_busy", 32'(busy), 0);
        step(); #1;
        check("a_grant2_sel", 32'(valve_sel), 4);
        fill_req = 4'b0000;
        #1;
        check("a_drop_no_done", 32'(fill_done), 0);
        step(); #1;
        check("a_drop_closed", 32'(valve_open), 0);
        check("a_drop_no_fault", 32'(fault), 0);

        // Timeout on machine 0 with a coinciding fault_clr, then exclusion and clear
        do_reset();
        power    = 1'b1;
        fill_req = 4'b0001;
        step(); #1;
        check("b_grant0", 32'(valve_sel), 1);
        repeat (11) step();
        #1;
        check("b_still_open_c11", 32'(valve_open), 1);
        fault_clr = 4'b0001;
        step();
        fault_clr = '0;
        #1;
        check("b_fault_set_wins", 32'(fault), 1);
        check("b_timeout_closed", 32'(valve_open), 0);
        step();
        step(); #1;
        check("b_excluded_busy", 32'(busy), 0);
        fault_clr = 4'b0001;
        step();
        fault_clr = '0;
        #1;
        check("b_fault_cleared", 32'(fault), 0);
        step(); #1;
        check("b_regrant0", 32'(valve_sel), 1);
        fill_req = '0;

        // All request with water already full: 0,1,2,3,0 every 3 cycles
        do_reset();
        power      = 1'b1;
        fill_req   = 4'b1111;
        water_full = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step(); #1;
            check("c_rotate_sel", 32'(valve_sel), 32'(1 << (k % 4)));
            check("c_rotate_done", 32'(fill_done), 32'(1 << (k % 4)));
            step(); #1;
            check("c_close", 32'({busy, valve_open}), 2);
            step(); #1;
            check("c_idle", 32'({busy, valve_open}), 0);
        end
        fill_req   = '0;
        water_full = '0;

        // Power drop mid-fill on machine 1: no pulse, pointer not advanced
        do_reset();
        power    = 1'b1;
        fill_req = 4'b0010;
        step(); #1;
        check("d_grant1", 32'(valve_sel), 2);
        step();
        power      = 1'b0;
        water_full = 4'b0010;
        #1;
        check("d_done_suppressed", 32'(fill_done), 0);
        step();
        water_full = '0;
        #1;
        check("d_valve_off", 32'({busy, valve_open}), 0);
        fill_req = 4'b0110;
        repeat (3) step();
        power = 1'b1;
        step(); #1;
        check("d_regrant1", 32'(valve_sel), 2);
        fill_req = '0;

        // Asynchronous reset mid-fill closes the valve without a clock edge
        do_reset();
        power    = 1'b1;
        fill_req = 4'b1000;
        step();
        step(); #1;
        check("e_open_before", 32'(valve_open), 1);
        reset_n = 1'b0;
        #1;
        check("e_async_outputs", 32'({valve_open, valve_sel, fill_done, fault, busy}), 0);

        // Randomized traffic, checked every cycle by the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            step();
            power = ($urandom_range(0, 31) != 0);
            for (int b = 0; b < N; b++) begin
                if (fill_req[b]) fill_req[b] = ($urandom_range(0, 23) != 0);
                else fill_req[b] = ($urandom_range(0, 3) == 0);
                water_full[b] = ($urandom_range(0, 13) == 0);
                fault_clr[b]  = ($urandom_range(0, 39) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
